id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage RV32I core.
- Takes the IF/ID instruction, drives the register-file read addresses and captures the read data.
- Bypasses same-cycle write-back data, generates the immediate and decodes the control bits.
- Detects load-use hazards, stalls upstream and injects bubbles; honours flushes from branch resolution.

Parameters:
- XLEN, 32, datapath width.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  instruction PC.
- rf_rreg1  out  5  register-file read address 1; equals if_instr[19:15].
- rf_rreg2  out  5  register-file read address 2; equals if_instr[24:20].
- rf_read1  in  XLEN  register-file read data 1 (combinational).
- rf_read2  in  XLEN  register-file read data 2 (combinational).
- wb_we  in  1  write-back write enable (same signal as the regfile write enable).
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back data.
- ex_flush  in  1  branch/jump taken in EX; kill the instruction in decode.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX entry valid.
- ex_pc  out  XLEN  PC of the instruction in EX.
- ex_rs1_data  out  XLEN  operand 1.
- ex_rs2_data  out  XLEN  operand 2.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1  out  5  source register 1, for the EX forwarding unit.
- ex_rs2  out  5  source register 2, for the EX forwarding unit.
- ex_rd  out  5  destination register.
- ex_opcode  out  7  opcode.
- ex_funct3  out  3  funct3.
- ex_funct7b5  out  1  instr[30].
- ex_reg_write  out  1  instruction writes rd.
- ex_mem_read  out  1  instruction is a load.
- ex_mem_write  out  1  instruction is a store.
- stall_cnt  out  STALL_CNT_W  count of stall cycles, saturating.

Behaviour:
- Reset: all ex_* outputs go to 0 (ex_valid=0 is a bubble) and stall_cnt goes to 0 asynchronously. stall is combinational, so it is 0 during reset because ex_valid=0.
- Source use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by R-type, STORE and BRANCH.
  - A source register of x0 never counts as a hazard.
- Operand bypass (combinational, before capture): when wb_we=1, wb_rd!=0 and wb_rd==rs1, use wb_data instead of rf_read1. The same rule applies to rs2. This is needed because the register file writes at the clock edge.
- Load-use hazard: stall=1 when all of the following hold:
  - if_valid=1 and ex_valid=1 and ex_mem_read=1 and ex_rd!=0;
  - ex_rd matches a used rs1 or a used rs2;
  - ex_flush=0.
- Register update at each rising edge, highest priority first:
  1. ex_flush=1: load a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0). Flush wins over stall.
  2. stall=1: load a bubble. IF/ID is held externally.
  3. if_valid=0: load a bubble.
  4. Otherwise capture the decoded instruction. ex_valid=1; ex_reg_write=1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR, and is forced to 0 when rd=0.
- Bubble contents: data fields of a bubble are don't-care, but the design zeroes them for deterministic waveforms.
- Unknown opcode: captured with ex_valid=1 and all control bits 0, i.e. it behaves as a NOP. No trap is raised.
- Immediate formats: I, S, B, U and J per the RV32I spec; 0 for R-type.
- stall_cnt: increments on every edge where stall=1 and saturates at all-ones without wrapping.
- Latency: decode is one cycle; ID/EX is valid the cycle after IF/ID presents the instruction.

Decomposition:
- Shared package riscv_pkg:
  - opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - XLEN default.
- Sub-module: imm_gen, combinational (instr -> imm_type -> 32-bit sign-extended immediate).

Test Plan:
- Reset mid-stream: assert RST_N=0 with ex_valid=1 -> all ex_* outputs are 0, stall=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- ADDI x5,x0,-3 (0xFFD00293), PC=0x100 -> next cycle ex_valid=1, ex_imm=0xFFFFFFFD, ex_rd=5, ex_reg_write=1, ex_pc=0x100.
- LW x6,0(x1) then ADD x7,x6,x2 -> one cycle with stall=1 and a bubble in ID/EX, then ADD captured; stall_cnt=1.
- LW x0,0(x1) then ADD x7,x0,x2 -> no stall.
- Bypass: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, rf_read1=0, decoding ADD x4,x3,x3 -> ex_rs1_data=ex_rs2_data=0xDEADBEEF. Repeat with wb_rd=0 -> register-file values are used.
- ex_flush=1 together with a load-use condition -> stall=0 and a bubble is captured. Separately, 2^STALL_CNT_W+3 forced stalls -> stall_cnt holds at all-ones.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the core pipeline.
//   XLEN         : default datapath width
//   OP_*         : major opcodes (instr[6:0])
//   imm_type_e   : immediate encoding selected by the decoder
//   imm_type_of  : opcode -> immediate encoding
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // R-type and unrecognised opcodes carry no immediate.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the RV32I immediate of the given format
// and sign-extends it to XLEN. Purely combinational.
//   instr    in  instruction bits [31:7] (opcode bits are not needed)
//   imm_type in  immediate format chosen by the decoder
//   imm      out sign-extended immediate (0 for IMM_NONE)
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [31:7]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register of the 5-stage RV32I core.
// Drives the register-file read ports from IF/ID, bypasses same-cycle
// write-back data, decodes the control bits and immediate, detects load-use
// hazards (stalling IF and inserting a bubble) and honours EX flushes.
//   CLK, RST_N            clock (rising edge), async active-low reset
//   if_valid/instr/pc     IF/ID contents
//   rf_rreg1/2, rf_read1/2 register-file read port (combinational data)
//   wb_we/rd/data         write-back port (written at the same clock edge)
//   ex_flush              taken branch/jump in EX kills the decode slot
//   stall                 hold PC and IF/ID this cycle
//   ex_*                  ID/EX register contents
//   stall_cnt             saturating count of stall cycles
// Handshake: there is no ready/valid back-pressure from EX; ex_valid marks a
// real instruction, ex_valid=0 is a bubble. stall is the only upstream
// back-pressure and is valid combinationally within the cycle it is raised.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [XLEN-1:0]        if_pc,
  output logic [4:0]             rf_rreg1,
  output logic [4:0]             rf_rreg2,
  input  logic [XLEN-1:0]        rf_read1,
  input  logic [XLEN-1:0]        rf_read2,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   ex_flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_rs1_data,
  output logic [XLEN-1:0]        ex_rs2_data,
  output logic [XLEN-1:0]        ex_imm,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic [6:0]             ex_opcode,
  output logic [2:0]             ex_funct3,
  output logic                   ex_funct7b5,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  assign rf_rreg1 = rs1;
  assign rf_rreg2 = rs2;

  // ID/EX register
  logic                   ex_valid_q,     ex_valid_d;
  logic [XLEN-1:0]        ex_pc_q,        ex_pc_d;
  logic [XLEN-1:0]        ex_rs1_data_q,  ex_rs1_data_d;
  logic [XLEN-1:0]        ex_rs2_data_q,  ex_rs2_data_d;
  logic [XLEN-1:0]        ex_imm_q,       ex_imm_d;
  logic [4:0]             ex_rs1_q,       ex_rs1_d;
  logic [4:0]             ex_rs2_q,       ex_rs2_d;
  logic [4:0]             ex_rd_q,        ex_rd_d;
  logic [6:0]             ex_opcode_q,    ex_opcode_d;
  logic [2:0]             ex_funct3_q,    ex_funct3_d;
  logic                   ex_funct7b5_q,  ex_funct7b5_d;
  logic                   ex_reg_write_q, ex_reg_write_d;
  logic                   ex_mem_read_q,  ex_mem_read_d;
  logic                   ex_mem_write_q, ex_mem_write_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q,    stall_cnt_d;

  // Source usage: only used sources can create a load-use hazard.
  logic use_rs1, use_rs2;
  always_comb begin
    use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

  // The register file only updates at the clock edge, so a write-back in
  // this cycle must be forwarded into the value captured now.
  logic [XLEN-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_read1;
    rs2_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_read2;
  end

  // ex_rd_q != 0 also excludes x0 sources from matching.
  logic load_use;
  always_comb begin
    load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
               ((use_rs1 && rs1 == ex_rd_q) || (use_rs2 && rs2 == ex_rd_q));
  end

  // A flush kills the waiting instruction, so there is nothing to stall for.
  assign stall = if_valid && load_use && !ex_flush;

  // Control decode
  logic writes_rd, is_load, is_store;
  always_comb begin
    writes_rd = (opcode == OP_R)   || (opcode == OP_IMM)   || (opcode == OP_LOAD) ||
                (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL)  ||
                (opcode == OP_JALR);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
  end

  logic [XLEN-1:0] imm;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (if_instr[31:7]),
    .imm_type (imm_type_of(opcode)),
    .imm      (imm)
  );

  // Next ID/EX contents: bubbles are fully zeroed for deterministic traces.
  logic bubble;
  assign bubble = ex_flush || stall || !if_valid;

  always_comb begin
    ex_valid_d     = 1'b0;
    ex_pc_d        = '0;
    ex_rs1_data_d  = '0;
    ex_rs2_data_d  = '0;
    ex_imm_d       = '0;
    ex_rs1_d       = '0;
    ex_rs2_d       = '0;
    ex_rd_d        = '0;
    ex_opcode_d    = '0;
    ex_funct3_d    = '0;
    ex_funct7b5_d  = 1'b0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_mem_write_d = 1'b0;
    if (!bubble) begin
      ex_valid_d     = 1'b1;
      ex_pc_d        = if_pc;
      ex_rs1_data_d  = rs1_val;
      ex_rs2_data_d  = rs2_val;
      ex_imm_d       = imm;
      ex_rs1_d       = rs1;
      ex_rs2_d       = rs2;
      ex_rd_d        = rd;
      ex_opcode_d    = opcode;
      ex_funct3_d    = if_instr[14:12];
      ex_funct7b5_d  = if_instr[30];
      ex_reg_write_d = writes_rd && (rd != 5'd0);
      ex_mem_read_d  = is_load;
      ex_mem_write_d = is_store;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_opcode_q    <= '0;
      ex_funct3_q    <= '0;
      ex_funct7b5_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_opcode_q    <= ex_opcode_d;
      ex_funct3_q    <= ex_funct3_d;
      ex_funct7b5_q  <= ex_funct7b5_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7b5  = ex_funct7b5_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
